arm_link: RTL and testbench
===========================

ARM_LINK -- requirements
Module: arm_link

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of a transmitter word serialised to the ARM.
REQ-002 SHALL have parameter RES_W, default 8: width of a result word assembled from the ARM.
REQ-003 SHALL have parameter NIB_W, default 4: width of the ARM parallel return bus; RES_W must be a multiple of NIB_W (elaboration error otherwise).
REQ-004 SHALL have parameter DEPTH, default 4: inbound word FIFO depth, power of two, >=2.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 sclk  input  1  ARM serial clock, asynchronous to clk.
REQ-008 arm_sync  input  1  ARM framing pulse (asynchronous); restarts result assembly.
REQ-009 in_valid  input  1  transmitter word valid.
REQ-010 in_data  input  DATA_W  transmitter word.
REQ-011 in_ready  output  1  FIFO can accept a word.
REQ-012 from_arm  input  NIB_W  ARM result slice.
REQ-013 to_arm  output  1  serial bit to the ARM, LSB first.
REQ-014 arm_frame  output  1  high while a word is being shifted to the ARM.
REQ-015 out_valid  output  1  one-cycle pulse: out_data holds a new result.
REQ-016 out_data  output  RES_W  assembled ARM result.
REQ-017 fifo_level  output  $clog2(DEPTH)+1  words held in the FIFO.
REQ-018 overflow  output  1  sticky: in_valid seen while in_ready low.

Function
REQ-019 sclk and arm_sync SHALL each pass a 2-flop synchroniser; sclk_rise is a one-clk pulse on a synchronised 0->1 transition; the ARM holds each sclk level >=3 clk.
REQ-020 A word SHALL be pushed when in_valid && in_ready; in_ready = !full from registered state, so a push is refused while full even if a pop occurs that cycle.
REQ-021 Serializer FSM SHALL have states IDLE and SHIFT; IDLE: to_arm=0, arm_frame=0.
REQ-022 In IDLE on sclk_rise with FIFO non-empty: pop the word, drive to_arm=bit0, set bit counter to 1, arm_frame=1, go to SHIFT; FIFO empty: stay IDLE.
REQ-023 In SHIFT on each sclk_rise: drive the next bit; on the sclk_rise after bit DATA_W-1 has been presented, pop the next word if present (back-to-back, no gap), else return to IDLE with arm_frame=0.
REQ-024 Deserializer SHALL store from_arm into slice k (bits k*NIB_W+NIB_W-1:k*NIB_W) on each sclk_rise, k starting at 0 (LSB slice first).
REQ-025 After slice RES_W/NIB_W-1 is stored, out_data SHALL update and out_valid SHALL pulse on the next clk; k wraps to 0.
REQ-026 A synchronised arm_sync rising edge SHALL set k=0 and discard the partial result; when coincident with sclk_rise, the slice is stored as k=0.
REQ-027 Push and pop in the same cycle SHALL leave fifo_level unchanged; fifo_level never exceeds DEPTH or underflows.
REQ-028 overflow SHALL set on in_valid && !in_ready and clear only on reset.

Reset
REQ-029 While rst=0: FIFO emptied, fifo_level=0, in_ready=1 from the first cycle after release, FSM=IDLE, to_arm=0, arm_frame=0, out_valid=0, out_data=0, k=0, overflow=0, synchroniser flops=0.
REQ-030 Reset mid-word SHALL abandon the shift and the partial result; no out_valid follows release.

Structure
REQ-031 Package arm_link_pkg SHALL hold the default parameter values and the serializer state enum (IDLE, SHIFT).
REQ-032 The FIFO SHALL be one sub-module, sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level).

Verification
REQ-033 Push 16'hA5C3, apply 16 sclk pulses -> to_arm sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; arm_frame high for exactly the 16 bits.
REQ-034 from_arm=4'h7 then 4'hB on two sclk pulses -> out_data=8'hB7 with a single out_valid pulse.
REQ-035 Push 5 words with DEPTH=4 and no sclk -> in_ready=0 after the 4th push, 5th refused, overflow=1, fifo_level=4.
REQ-036 Two words queued, 32 sclk pulses -> both words shifted contiguously, arm_frame never drops between them, IDLE afterwards.
REQ-037 One slice, then arm_sync, then slices 4'h2 and 4'h9 -> out_data=8'h92; the stale slice is discarded.
REQ-038 rst low after 5 of 16 bits -> all outputs at reset values; the next word starts at bit0.

Source files
------------

// File: rtl/arm_link_pkg.sv
// arm_link_pkg: shared defaults and types for the ARM serial link.
//   DATA_W_DEF : transmitter word width serialised to the ARM
//   RES_W_DEF  : result word width assembled from the ARM
//   NIB_W_DEF  : ARM parallel return bus width
//   DEPTH_DEF  : inbound word FIFO depth
//   ser_state_e: serializer FSM states
package arm_link_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned RES_W_DEF  = 8;
  localparam int unsigned NIB_W_DEF  = 4;
  localparam int unsigned DEPTH_DEF  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/arm_link_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, rst (sync, active-low)
//   push/wr_data : write request, ignored while full
//   pop/rd_data  : read request, ignored while empty; rd_data shows the head word
//   full/empty   : derived from the registered level only
//   level        : words currently held
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two and >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/arm_link.sv
// arm_link: word FIFO + LSB-first serializer toward the ARM, and a slice
// deserializer assembling results returned on a parallel bus.
//   clk, rst (sync, active-low)
//   sclk, arm_sync      : asynchronous ARM serial clock and framing pulse
//   in_valid/in_data    : transmitter words, accepted when in_ready
//   to_arm, arm_frame   : serial bit and frame indicator toward the ARM
//   from_arm            : ARM result slice, captured on each sclk rise
//   out_valid/out_data  : one-cycle pulse with an assembled result
//   fifo_level          : words queued; overflow: sticky refused-push flag
module arm_link
  import arm_link_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned RES_W  = RES_W_DEF,
  parameter int unsigned NIB_W  = NIB_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sclk,
  input  logic                   arm_sync,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  input  logic [NIB_W-1:0]       from_arm,
  output logic                   to_arm,
  output logic                   arm_frame,
  output logic                   out_valid,
  output logic [RES_W-1:0]       out_data,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow
);

  localparam int unsigned SLICES = RES_W / NIB_W;
  localparam int unsigned K_W    = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);

  if (RES_W % NIB_W != 0) begin : g_bad_res
    $error("arm_link: RES_W must be a multiple of NIB_W");
  end

  // Synchronisers and edge detect
  logic sclk_meta_q, sclk_meta_d, sclk_sync_q, sclk_sync_d, sclk_del_q, sclk_del_d;
  logic sync_meta_q, sync_meta_d, sync_sync_q, sync_sync_d, sync_del_q, sync_del_d;
  logic sclk_rise, sync_rise;

  // FIFO
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [DATA_W-1:0] fifo_rd;

  // Serializer
  ser_state_e        state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              to_arm_q, to_arm_d;
  logic              frame_q, frame_d;

  // Deserializer
  logic [K_W-1:0]    k_q, k_d, k_idx;
  logic [RES_W-1:0]  part_q, part_d;
  logic [RES_W-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic              overflow_q, overflow_d;

  assign sclk_rise = sclk_sync_q & ~sclk_del_q;
  assign sync_rise = sync_sync_q & ~sync_del_q;
  assign in_ready  = !fifo_full;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (in_valid),
    .wr_data (in_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    sclk_meta_d = sclk;
    sclk_sync_d = sclk_meta_q;
    sclk_del_d  = sclk_sync_q;
    sync_meta_d = arm_sync;
    sync_sync_d = sync_meta_q;
    sync_del_d  = sync_sync_q;
    overflow_d  = overflow_q | (in_valid & ~in_ready);
  end

  // Serializer: the word after the last bit is loaded on the same sclk rise
  // that would otherwise end the frame, so queued words leave with no gap.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    to_arm_d  = to_arm_q;
    frame_d   = frame_q;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        to_arm_d = 1'b0;
        frame_d  = 1'b0;
        if (sclk_rise && !fifo_empty) begin
          fifo_pop  = 1'b1;
          to_arm_d  = fifo_rd[0];
          shreg_d   = fifo_rd >> 1;
          bit_cnt_d = CNT_W'(1);
          frame_d   = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          if (bit_cnt_q == CNT_W'(DATA_W)) begin
            if (!fifo_empty) begin
              fifo_pop  = 1'b1;
              to_arm_d  = fifo_rd[0];
              shreg_d   = fifo_rd >> 1;
              bit_cnt_d = CNT_W'(1);
            end else begin
              to_arm_d = 1'b0;
              frame_d  = 1'b0;
              state_d  = IDLE;
            end
          end else begin
            to_arm_d  = shreg_q[0];
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Deserializer: a framing edge restarts at slice 0 and drops the partial
  // result; a coincident sclk rise stores its slice as slice 0.
  always_comb begin
    k_d         = k_q;
    part_d      = part_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    k_idx       = k_q;
    if (sync_rise) begin
      k_idx  = '0;
      k_d    = '0;
      part_d = '0;
    end
    if (sclk_rise) begin
      part_d[32'(k_idx) * NIB_W +: NIB_W] = from_arm;
      if (k_idx == K_W'(SLICES - 1)) begin
        out_data_d  = part_d;
        out_valid_d = 1'b1;
        k_d         = '0;
      end else begin
        k_d = k_idx + K_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_del_q  <= 1'b0;
      sync_meta_q <= 1'b0;
      sync_sync_q <= 1'b0;
      sync_del_q  <= 1'b0;
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      to_arm_q    <= 1'b0;
      frame_q     <= 1'b0;
      k_q         <= '0;
      part_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sclk_meta_q <= sclk_meta_d;
      sclk_sync_q <= sclk_sync_d;
      sclk_del_q  <= sclk_del_d;
      sync_meta_q <= sync_meta_d;
      sync_sync_q <= sync_sync_d;
      sync_del_q  <= sync_del_d;
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      to_arm_q    <= to_arm_d;
      frame_q     <= frame_d;
      k_q         <= k_d;
      part_q      <= part_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign to_arm    = to_arm_q;
  assign arm_frame = frame_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_arm_link.sv
// tb_arm_link: scoreboard bench for arm_link with default parameters.
// Expected serial bits and assembled results are queued when stimulus is
// driven and compared when the DUT presents them.
module tb_arm_link;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned RES_W  = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned DEPTH  = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   sclk;
  logic                   arm_sync;
  logic                   in_valid;
  logic [DATA_W-1:0]      in_data;
  logic                   in_ready;
  logic [NIB_W-1:0]       from_arm;
  logic                   to_arm;
  logic                   arm_frame;
  logic                   out_valid;
  logic [RES_W-1:0]       out_data;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   overflow;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic             exp_bits [$];
  logic [RES_W-1:0] exp_res  [$];
  int unsigned      tb_k;
  logic [RES_W-1:0] tb_part;

  always #5 clk = ~clk;

  arm_link #(
    .DATA_W (DATA_W),
    .RES_W  (RES_W),
    .NIB_W  (NIB_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .arm_sync   (arm_sync),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .from_arm   (from_arm),
    .to_arm     (to_arm),
    .arm_frame  (arm_frame),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Result scoreboard: every out_valid cycle must match a queued result.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (exp_res.size() == 0) check("out_valid_spurious", out_valid, 1'b0);
      else check("out_data", out_data, exp_res.pop_front());
    end
  end

  task automatic model_clear();
    exp_bits.delete();
    tb_k    = 0;
    tb_part = '0;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w, input logic accept);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    if (accept) begin
      for (int i = 0; i < DATA_W; i++) exp_bits.push_back(w[i]);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // One sclk period (4 clk high, 4 clk low) carrying a result slice, with an
  // optional coincident arm_sync; the serial output is checked at its end.
  task automatic sclk_pulse(input logic [NIB_W-1:0] nib, input logic with_sync);
    logic b;
    @(negedge clk);
    from_arm = nib;
    sclk     = 1'b1;
    arm_sync = with_sync;
    if (with_sync) begin
      tb_k    = 0;
      tb_part = '0;
    end
    tb_part[tb_k*NIB_W +: NIB_W] = nib;
    if (tb_k == RES_W / NIB_W - 1) begin
      exp_res.push_back(tb_part);
      tb_k = 0;
    end else begin
      tb_k++;
    end
    repeat (4) @(negedge clk);
    sclk     = 1'b0;
    arm_sync = 1'b0;
    repeat (4) @(negedge clk);
    if (exp_bits.size() > 0) begin
      b = exp_bits.pop_front();
      check("to_arm", to_arm, b);
      check("arm_frame_on", arm_frame, 1'b1);
    end else begin
      check("to_arm_idle", to_arm, 1'b0);
      check("arm_frame_off", arm_frame, 1'b0);
    end
  endtask

  task automatic sync_pulse();
    @(negedge clk);
    arm_sync = 1'b1;
    tb_k     = 0;
    tb_part  = '0;
    repeat (4) @(negedge clk);
    arm_sync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic rand_pulses(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) sclk_pulse(NIB_W'($urandom), 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_to_arm"}, to_arm, 1'b0);
    check({tag, "_arm_frame"}, arm_frame, 1'b0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_data"}, out_data, '0);
    check({tag, "_fifo_level"}, fifo_level, '0);
    check({tag, "_overflow"}, overflow, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    logic [DATA_W-1:0] w;
    logic [15:0]       golden;
    rst      = 1'b0;
    sclk     = 1'b0;
    arm_sync = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    from_arm = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;
    @(negedge clk);
    check("release_in_ready", in_ready, 1'b1);

    // Known word: LSB-first bits of A5C3, frame drops on the 17th rise.
    golden = 16'b1010_0101_1100_0011;
    push_word(16'hA5C3, 1'b1);
    check("level_one", fifo_level, 1);
    for (int i = 0; i < 16; i++) begin
      sclk_pulse(NIB_W'($urandom), 1'b0);
      if (i == 0) check("level_after_pop", fifo_level, 0);
      check("a5c3_bit", to_arm, golden[i]);
    end
    sclk_pulse(NIB_W'($urandom), 1'b0);

    // Two slices 7 then B assemble to B7.
    sync_pulse();
    sclk_pulse(4'h7, 1'b0);
    sclk_pulse(4'hB, 1'b0);
    check("b7_drained", exp_res.size(), 0);

    // Fill past depth with no sclk.
    for (int i = 0; i < 5; i++) begin
      w = DATA_W'($urandom);
      push_word(w, (i < 4) ? 1'b1 : 1'b0);
      if (i == 3) check("in_ready_full", in_ready, 1'b0);
    end
    check("overflow_set", overflow, 1'b1);
    check("level_full", fifo_level, DEPTH);
    rand_pulses(4 * DATA_W + 1);
    check("overflow_sticky", overflow, 1'b1);
    check("level_drained", fifo_level, 0);

    // Two queued words shifted back to back, then idle.
    push_word(DATA_W'($urandom), 1'b1);
    push_word(DATA_W'($urandom), 1'b1);
    rand_pulses(2 * DATA_W + 1);

    // Stale slice discarded by arm_sync.
    sync_pulse();
    sclk_pulse(4'h5, 1'b0);
    sync_pulse();
    sclk_pulse(4'h2, 1'b0);
    sclk_pulse(4'h9, 1'b0);
    check("92_drained", exp_res.size(), 0);

    // arm_sync coincident with an sclk rise: that slice becomes slice 0.
    sclk_pulse(4'h6, 1'b0);
    sclk_pulse(4'h3, 1'b1);
    sclk_pulse(4'hC, 1'b0);
    check("c3_drained", exp_res.size(), 0);

    // Reset mid-word, then a fresh word starts at bit 0.
    push_word(16'hA5C3, 1'b1);
    push_word(16'h1234, 1'b1);
    rand_pulses(5);
    @(negedge clk);
    rst = 1'b0;
    exp_res.delete();
    model_clear();
    repeat (3) @(negedge clk);
    check_reset_values("midword_reset");
    rst = 1'b1;
    repeat (12) @(negedge clk);
    check("post_reset_no_valid", out_valid, 1'b0);
    push_word(16'h8001, 1'b1);
    sclk_pulse(4'h1, 1'b0);
    check("restart_bit0", to_arm, 1'b1);
    rand_pulses(DATA_W);

    check("bits_drained", exp_bits.size(), 0);
    check("results_drained", exp_res.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no end expected finish");
    $fatal(1, "timeout");
  end

endmodule
